// File: rtl/core_avl_arbiter.sv
// Two-master / one-slave Avalon-style arbiter with in-order read response routing.
// m0 = instruction fetch, m1 = memory stage. A small ID FIFO remembers which
// master issued each accepted read, so returning beats go back to the right port.
module core_avl_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int FIXED_PRIORITY  = 0
) (
    input  logic                               clk,
    input  logic                               rest,
    input  logic [31:0]                        m0_address,
    input  logic [3:0]                         m0_byte_en,
    input  logic                               m0_read,
    input  logic                               m0_write,
    input  logic [31:0]                        m0_write_data,
    output logic                               m0_request_ready,
    output logic [31:0]                        m0_read_data,
    output logic                               m0_read_data_valid,
    input  logic [31:0]                        m1_address,
    input  logic [3:0]                         m1_byte_en,
    input  logic                               m1_read,
    input  logic                               m1_write,
    input  logic [31:0]                        m1_write_data,
    output logic                               m1_request_ready,
    output logic [31:0]                        m1_read_data,
    output logic                               m1_read_data_valid,
    output logic [31:0]                        s_address,
    output logic [3:0]                         s_byte_en,
    output logic                               s_read,
    output logic                               s_write,
    output logic [31:0]                        s_write_data,
    input  logic                               s_request_ready,
    input  logic [31:0]                        s_read_data,
    input  logic                               s_read_data_valid,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               resp_error
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    logic [MAX_OUTSTANDING-1:0] id_mem;
    logic [PW-1:0]              wr_ptr, rd_ptr;
    logic [CW-1:0]              count;
    logic                       lock, lock_id, rr_ptr, resp_err_q;

    logic req0, req1, elig0, elig1, full, empty;
    logic grant, g_read, g_write, g_req, blocked, accept, push, pop, head;

    assign req0  = m0_read | m0_write;
    assign req1  = m1_read | m1_write;
    assign full  = (count == CNT_MAX);
    assign empty = (count == '0);
    // A read stuck behind a full FIFO steps out of arbitration so a write can pass.
    assign elig0 = req0 & ~(m0_read & full);
    assign elig1 = req1 & ~(m1_read & full);

    // Grant selection: lock first, then eligible requesters; idle parks on m1.
    always_comb begin
        grant = 1'b1;
        if (lock)
            grant = lock_id;
        else if (elig0 && elig1)
            grant = (FIXED_PRIORITY != 0) ? 1'b1 : rr_ptr;
        else if (elig0)
            grant = 1'b0;
        else if (elig1)
            grant = 1'b1;
        else if (req0 && !req1)
            grant = 1'b0;
    end

    // Command mux from the granted master onto the slave bus.
    always_comb begin
        s_address    = grant ? m1_address    : m0_address;
        s_byte_en    = grant ? m1_byte_en    : m0_byte_en;
        s_write_data = grant ? m1_write_data : m0_write_data;
        g_read       = grant ? m1_read       : m0_read;
        g_write      = grant ? m1_write      : m0_write;
        g_req        = grant ? req1          : req0;
    end

    assign blocked = g_read & full;
    assign s_read  = rest & g_read & ~blocked;
    assign s_write = rest & g_write;
    assign accept  = rest & s_request_ready & g_req & ~blocked;

    assign m0_request_ready = accept & ~grant;
    assign m1_request_ready = accept & grant;

    assign push = accept & g_read;
    assign pop  = rest & s_read_data_valid & ~empty;
    assign head = id_mem[rd_ptr];

    assign m0_read_data       = s_read_data;
    assign m1_read_data       = s_read_data;
    assign m0_read_data_valid = pop & ~head;
    assign m1_read_data_valid = pop & head;

    assign outstanding = count;
    assign resp_error  = resp_err_q;

    // Read-ID FIFO plus the sticky "beat with nothing outstanding" flag.
    always_ff @(posedge clk) begin
        if (!rest) begin
            id_mem     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            resp_err_q <= 1'b0;
        end else begin
            if (push) begin
                id_mem[wr_ptr] <= grant;
                wr_ptr         <= wr_ptr + PTR_ONE;
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
                count <= count + CNT_ONE;
            else if (!push && pop)
                count <= count - CNT_ONE;
            if (s_read_data_valid && empty)
                resp_err_q <= 1'b1;
        end
    end

    // Grant lock while the slave stalls a presented command; round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rest) begin
            lock    <= 1'b0;
            lock_id <= 1'b0;
            rr_ptr  <= 1'b1;
        end else if (accept) begin
            lock   <= 1'b0;
            rr_ptr <= ~grant;
        end else if ((s_read || s_write) && !s_request_ready) begin
            lock    <= 1'b1;
            lock_id <= grant;
        end
    end
endmodule

// File: tb/tb_core_avl_arbiter.sv
// Bench for core_avl_arbiter: directed scenarios plus randomized traffic,
// all checked against a queue-based model of arbitration and response order.
module tb_core_avl_arbiter;
    localparam int MO = 4;
    localparam int OW = $clog2(MO) + 1;

    logic clk = 1'b0;
    logic rest;
    logic [31:0] m0_address, m0_write_data, m1_address, m1_write_data;
    logic [3:0]  m0_byte_en, m1_byte_en;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic        m0_request_ready, m1_request_ready;
    logic [31:0] m0_read_data, m1_read_data;
    logic        m0_read_data_valid, m1_read_data_valid;
    logic [31:0] s_address, s_write_data, s_read_data;
    logic [3:0]  s_byte_en;
    logic        s_read, s_write, s_request_ready, s_read_data_valid;
    logic [OW-1:0] outstanding;
    logic        resp_error;

    always #5 clk = ~clk;

    core_avl_arbiter #(.MAX_OUTSTANDING(MO), .FIXED_PRIORITY(0)) dut (
        .clk(clk), .rest(rest),
        .m0_address(m0_address), .m0_byte_en(m0_byte_en), .m0_read(m0_read),
        .m0_write(m0_write), .m0_write_data(m0_write_data),
        .m0_request_ready(m0_request_ready), .m0_read_data(m0_read_data),
        .m0_read_data_valid(m0_read_data_valid),
        .m1_address(m1_address), .m1_byte_en(m1_byte_en), .m1_read(m1_read),
        .m1_write(m1_write), .m1_write_data(m1_write_data),
        .m1_request_ready(m1_request_ready), .m1_read_data(m1_read_data),
        .m1_read_data_valid(m1_read_data_valid),
        .s_address(s_address), .s_byte_en(s_byte_en), .s_read(s_read),
        .s_write(s_write), .s_write_data(s_write_data),
        .s_request_ready(s_request_ready), .s_read_data(s_read_data),
        .s_read_data_valid(s_read_data_valid),
        .outstanding(outstanding), .resp_error(resp_error)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: queue of issuing IDs, lock, round-robin preference, sticky error.
    bit q[$];
    bit lock_v, rr, rerr;
    int lock_id;
    bit acc0, acc1;

    task automatic set_m(input int n, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        if (n == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_write_data = d; m0_byte_en = be;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_write_data = d; m1_byte_en = be;
        end
    endtask

    task automatic idle();
        set_m(0, 0, 0, 32'h0, 32'h0, 4'h0);
        set_m(1, 0, 0, 32'h0, 32'h0, 4'h0);
        s_read_data_valid = 0;
    endtask

    // Check one cycle against the model, clock it, and advance the model.
    task automatic tick();
        bit r0, r1, c0, c1, full, acc, hd;
        int g;
        #1;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        acc = 0;
        g = -1;
        if (!rest) begin
            chk("rst_m0_rdy", m0_request_ready, 0);
            chk("rst_m1_rdy", m1_request_ready, 0);
            chk("rst_s_read", s_read, 0);
            chk("rst_s_write", s_write, 0);
            chk("rst_m0_vld", m0_read_data_valid, 0);
            chk("rst_m1_vld", m1_read_data_valid, 0);
        end else begin
            full = (q.size() >= MO);
            c0 = r0 && !(m0_read && full);
            c1 = r1 && !(m1_read && full);
            if (lock_v)        g = lock_id;
            else if (c0 && c1) g = rr;
            else if (c0)       g = 0;
            else if (c1)       g = 1;
            acc = (g >= 0) && s_request_ready;
            chk("m0_rdy", m0_request_ready, acc && g == 0);
            chk("m1_rdy", m1_request_ready, acc && g == 1);
            if (g >= 0) begin
                chk("s_addr",  s_address,    g ? m1_address    : m0_address);
                chk("s_wdata", s_write_data, g ? m1_write_data : m0_write_data);
                chk("s_be",    s_byte_en,    g ? m1_byte_en    : m0_byte_en);
                chk("s_read",  s_read,       g ? m1_read       : m0_read);
                chk("s_write", s_write,      g ? m1_write      : m0_write);
            end else begin
                chk("s_read_idle",  s_read, 0);
                chk("s_write_idle", s_write, 0);
            end
            hd = (q.size() > 0) ? q[0] : 1'b0;
            chk("m0_vld", m0_read_data_valid, s_read_data_valid && q.size() > 0 && hd == 0);
            chk("m1_vld", m1_read_data_valid, s_read_data_valid && q.size() > 0 && hd == 1);
            if (s_read_data_valid) begin
                chk("m0_rdata", m0_read_data, s_read_data);
                chk("m1_rdata", m1_read_data, s_read_data);
            end
        end
        chk("outstanding", outstanding, q.size());
        chk("resp_error", resp_error, rerr);
        acc0 = acc && g == 0;
        acc1 = acc && g == 1;
        @(posedge clk);
        if (!rest) begin
            q.delete(); lock_v = 0; rr = 1; rerr = 0; lock_id = 0;
        end else begin
            if (s_read_data_valid) begin
                if (q.size() > 0) void'(q.pop_front());
                else rerr = 1;
            end
            if (acc) begin
                if (g ? m1_read : m0_read) q.push_back(g[0]);
                rr = (g == 0);
                lock_v = 0;
            end else if (g >= 0) begin
                lock_v = 1;
                lock_id = g;
            end
        end
        @(negedge clk);
    endtask

    task automatic beat(input logic [31:0] d);
        s_read_data_valid = 1; s_read_data = d;
        tick();
        s_read_data_valid = 0;
    endtask

    initial begin
        bit exp1;
        idle();
        s_read_data = 32'h0; s_request_ready = 1;
        lock_v = 0; rr = 1; rerr = 0; lock_id = 0;
        @(negedge clk);

        // Reset with a read pending: nothing may be accepted or issued.
        rest = 0;
        set_m(0, 1, 0, 32'h40, 32'h0, 4'hF);
        tick(); tick();
        idle();
        rest = 1;
        tick();

        // Single read, beat three cycles later.
        set_m(0, 1, 0, 32'h100, 32'h0, 4'hF);
        #1; chk("single_rdy", m0_request_ready, 1);
        tick();
        idle();
        chk("single_out1", outstanding, 1);
        tick(); tick();
        s_read_data_valid = 1; s_read_data = 32'hDEADBEEF;
        #1;
        chk("single_vld0", m0_read_data_valid, 1);
        chk("single_vld1", m1_read_data_valid, 0);
        chk("single_data", m0_read_data, 32'hDEADBEEF);
        tick();
        s_read_data_valid = 0;
        chk("single_out0", outstanding, 0);

        // Both requesting continuously: grants alternate starting with m1.
        set_m(0, 1, 0, 32'h200, 32'h0, 4'hF);
        set_m(1, 0, 1, 32'h300, 32'h55AA, 4'h3);
        for (int i = 0; i < 8; i++) begin
            exp1 = (i % 2 == 0);
            #1;
            chk("alt_m1", m1_request_ready, exp1);
            chk("alt_m0", m0_request_ready, !exp1);
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) beat(32'h1000 + i);

        // Stall: m0 locked while m1 waits; m1 follows on release.
        s_request_ready = 0;
        set_m(0, 0, 1, 32'h400, 32'h11, 4'hF);
        tick();
        set_m(1, 0, 1, 32'h500, 32'h22, 4'hF);
        for (int i = 0; i < 3; i++) begin
            #1; chk("stall_addr", s_address, 32'h400);
            tick();
        end
        s_request_ready = 1;
        #1; chk("stall_m0_acc", m0_request_ready, 1);
        tick();
        set_m(0, 0, 0, 32'h0, 32'h0, 4'h0);
        #1; chk("stall_m1_next", m1_request_ready, 1);
        tick();
        idle();

        // Full FIFO: fifth read blocked, write passes, beat frees a slot.
        for (int i = 0; i < 4; i++) begin
            set_m(0, 1, 0, 32'h600 + i, 32'h0, 4'hF);
            tick();
        end
        set_m(0, 1, 0, 32'h700, 32'h0, 4'hF);
        set_m(1, 0, 1, 32'h800, 32'h33, 4'hF);
        #1;
        chk("full_sread", s_read, 0);
        chk("full_m0rdy", m0_request_ready, 0);
        chk("full_m1wr", m1_request_ready, 1);
        tick();
        set_m(1, 0, 0, 32'h0, 32'h0, 4'h0);
        s_read_data_valid = 1; s_read_data = 32'hA0;
        #1; chk("full_pop_blk", m0_request_ready, 0);
        tick();
        s_read_data_valid = 0;
        #1; chk("full_after", m0_request_ready, 1);
        tick();
        idle();
        for (int i = 0; i < 4; i++) beat(32'hB0 + i);

        // Ordering m0,m1,m1,m0 with a response overlapping an accept.
        set_m(0, 1, 0, 32'h900, 32'h0, 4'hF); tick(); idle();
        set_m(1, 1, 0, 32'h904, 32'h0, 4'hF); tick();
        set_m(1, 1, 0, 32'h908, 32'h0, 4'hF);
        s_read_data_valid = 1; s_read_data = 32'hC0;
        #1; chk("ord_overlap_v0", m0_read_data_valid, 1);
        tick(); idle();
        chk("ord_overlap_cnt", outstanding, 2);
        set_m(0, 1, 0, 32'h90C, 32'h0, 4'hF); tick(); idle();
        s_read_data_valid = 1; #1; chk("ord_b2", m1_read_data_valid, 1); tick();
        s_read_data_valid = 1; #1; chk("ord_b3", m1_read_data_valid, 1); tick();
        s_read_data_valid = 1; #1; chk("ord_b4", m0_read_data_valid, 1); tick();
        s_read_data_valid = 0;

        // Reset mid-flight: in-flight reads forgotten, late beat flags error.
        set_m(0, 1, 0, 32'hA00, 32'h0, 4'hF); tick(); idle();
        set_m(1, 1, 0, 32'hA04, 32'h0, 4'hF); tick(); idle();
        chk("mid_out2", outstanding, 2);
        rest = 0; tick(); rest = 1;
        chk("mid_out0", outstanding, 0);
        s_read_data_valid = 1; s_read_data = 32'hE0;
        #1;
        chk("mid_v0", m0_read_data_valid, 0);
        chk("mid_v1", m1_read_data_valid, 0);
        tick();
        s_read_data_valid = 0;
        chk("mid_err", resp_error, 1);

        // Randomized traffic; commands held until the model says accepted.
        rest = 0; tick(); rest = 1;
        for (int c = 0; c < 1500; c++) begin
            if (!(m0_read | m0_write) && $urandom_range(1) == 1) begin
                if ($urandom_range(1) == 1) set_m(0, 1, 0, $urandom, $urandom, 4'($urandom));
                else                        set_m(0, 0, 1, $urandom, $urandom, 4'($urandom));
            end
            if (!(m1_read | m1_write) && $urandom_range(1) == 1) begin
                if ($urandom_range(1) == 1) set_m(1, 1, 0, $urandom, $urandom, 4'($urandom));
                else                        set_m(1, 0, 1, $urandom, $urandom, 4'($urandom));
            end
            s_request_ready = ($urandom_range(3) != 0);
            s_read_data_valid = ($urandom_range(9) < 4) && (q.size() > 0 || $urandom_range(49) == 0);
            s_read_data = $urandom;
            if (c == 750) rest = 0;
            tick();
            rest = 1;
            if (acc0) set_m(0, 0, 0, 32'h0, 32'h0, 4'h0);
            if (acc1) set_m(1, 0, 0, 32'h0, 32'h0, 4'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
